pe_column_ctrl: RTL and testbench

- Sequences one column of NUM_ROWS PEs through a complete row-stationary 1D-conv pass: per-row weight bursts, per-row activation bursts, a broadcast compute start, then the systolic psum sum-up.
- Sits between the cluster-level data source (weight/activation streams) and the PE column.
- Drives the PEs' ctrl_loadw, ctrl_loada, ctrl_start, bottom ctrl_sums and the count config; consumes the PE done flags.

---
 rtl/pe_column_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pe_column_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_column_ctrl.sv
// Column sequencer for a row-stationary PE column: per-row weight and activation
// bursts, a broadcast compute start, then the systolic psum sum-up and drain.
module pe_column_ctrl #(
  parameter int NUM_ROWS   = 3,
  parameter int SPAD_DEPTH = 16,
  parameter int CNT_W      = 8,
  localparam int ROW_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [CNT_W-1:0]    cfg_wcount_i,
  input  logic [CNT_W-1:0]    cfg_acount_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                cfg_err_o,
  output logic                burst_err_o,
  input  logic                w_valid_i,
  output logic                w_ready_o,
  input  logic                a_valid_i,
  output logic                a_ready_o,
  output logic [ROW_W-1:0]    load_row_o,
  output logic [NUM_ROWS-1:0] pe_loadw_o,
  output logic [NUM_ROWS-1:0] pe_loada_o,
  output logic                pe_start_o,
  output logic                pe_sums_o,
  output logic [CNT_W-1:0]    pe_wcount_o,
  output logic [CNT_W-1:0]    pe_acount_o,
  input  logic [NUM_ROWS-1:0] pe_done_i,
  input  logic                top_sum_done_i
);

  localparam int XW = CNT_W + 1;
  localparam logic [NUM_ROWS-1:0] ROW0 = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_LOAD_A, S_START, S_COMPUTE, S_SUMS, S_DRAIN
  } state_t;

  state_t              state_q;
  logic [ROW_W-1:0]    row_q;
  logic [XW-1:0]       cnt_q;
  logic [XW-1:0]       nps_q;
  logic [NUM_ROWS-1:0] seen_q;
  logic [NUM_ROWS-1:0] seen_d;
  logic [CNT_W-1:0]    wcount_q;
  logic [CNT_W-1:0]    acount_q;
  logic                done_q;
  logic                cfg_err_q;
  logic                burst_err_q;
  logic                start_q;
  logic                sums_q;

  logic                in_w;
  logic                in_a;
  logic                xfer;
  logic                drop;
  logic                last_row;
  logic [XW-1:0]       burst_len;

  function automatic logic cfg_legal(input logic [CNT_W-1:0] w, input logic [CNT_W-1:0] a);
    logic [XW-1:0] wx;
    logic [XW-1:0] ax;
    logic [XW-1:0] nps;
    wx  = {1'b0, w};
    ax  = {1'b0, a};
    nps = ax - wx + XW'(2);
    return (wx >= XW'(1)) && (wx <= ax) && (ax <= XW'(SPAD_DEPTH)) && (nps <= XW'(SPAD_DEPTH));
  endfunction

  always_comb begin
    in_w      = (state_q == S_LOAD_W);
    in_a      = (state_q == S_LOAD_A);
    xfer      = (in_w & w_valid_i) | (in_a & a_valid_i);
    // A gap after the first word breaks the burst: the PE has already moved its spad pointer.
    drop      = (in_w | in_a) & ~xfer & (cnt_q != '0);
    burst_len = in_a ? {1'b0, acount_q} : {1'b0, wcount_q};
    last_row  = (row_q == ROW_W'(NUM_ROWS - 1));
    seen_d    = seen_q | pe_done_i;
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign cfg_err_o   = cfg_err_q;
  assign burst_err_o = burst_err_q;
  assign w_ready_o   = in_w & w_valid_i;
  assign a_ready_o   = in_a & a_valid_i;
  assign load_row_o  = (in_w | in_a) ? row_q : '0;
  assign pe_loadw_o  = w_ready_o ? (ROW0 << row_q) : '0;
  assign pe_loada_o  = a_ready_o ? (ROW0 << row_q) : '0;
  assign pe_start_o  = start_q;
  assign pe_sums_o   = sums_q;
  assign pe_wcount_o = wcount_q;
  assign pe_acount_o = acount_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      cnt_q       <= '0;
      nps_q       <= '0;
      seen_q      <= '0;
      wcount_q    <= '0;
      acount_q    <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      burst_err_q <= 1'b0;
      start_q     <= 1'b0;
      sums_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      burst_err_q <= 1'b0;
      start_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (cfg_legal(cfg_wcount_i, cfg_acount_i)) begin
              wcount_q <= cfg_wcount_i;
              acount_q <= cfg_acount_i;
              nps_q    <= {1'b0, cfg_acount_i} - {1'b0, cfg_wcount_i} + XW'(2);
              row_q    <= '0;
              cnt_q    <= '0;
              state_q  <= S_LOAD_W;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_LOAD_W, S_LOAD_A: begin
          if (xfer) begin
            if (cnt_q + XW'(1) == burst_len) begin
              cnt_q <= '0;
              if (last_row) begin
                row_q <= '0;
                if (in_a) begin
                  start_q <= 1'b1;
                  state_q <= S_START;
                end else begin
                  state_q <= S_LOAD_A;
                end
              end else begin
                row_q <= row_q + ROW_W'(1);
              end
            end else begin
              cnt_q <= cnt_q + XW'(1);
            end
          end else if (drop) begin
            cnt_q       <= '0;
            burst_err_q <= 1'b1;
          end
        end
        S_START: begin
          seen_q  <= '0;
          state_q <= S_COMPUTE;
        end
        S_COMPUTE: begin
          seen_q <= seen_d;
          if (&seen_d) begin
            cnt_q   <= '0;
            sums_q  <= 1'b1;
            state_q <= S_SUMS;
          end
        end
        S_SUMS: begin
          if (cnt_q + XW'(1) == nps_q) begin
            cnt_q  <= '0;
            sums_q <= 1'b0;
            // A single-row column can report its psum in the final sum cycle.
            if (top_sum_done_i) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DRAIN;
            end
          end else begin
            cnt_q <= cnt_q + XW'(1);
          end
        end
        S_DRAIN: begin
          if (top_sum_done_i) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_column_ctrl.sv
// Bench for pe_column_ctrl: a 3-row and a 1-row instance driven from a per-cycle
// expected timeline derived from burst/compute/sum-up rules.
module tb_pe_column_ctrl;

  localparam int MAXT = 600;
  localparam int SPAD = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start3, start1, w_valid, a_valid, top_done, pe_done1;
  logic [7:0] cfg_w, cfg_a;
  logic [2:0] pe_done3;

  logic       busy3, dn3, ce3, be3, wr3, ar3, st3, su3;
  logic [1:0] row3;
  logic [2:0] lw3, la3;
  logic [7:0] wc3, ac3;
  logic       busy1, dn1, ce1, be1, wr1, ar1, st1, su1;
  logic [0:0] row1, lw1, la1;
  logic [7:0] wc1, ac1;

  pe_column_ctrl #(.NUM_ROWS(3), .SPAD_DEPTH(SPAD), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start_i(start3), .cfg_wcount_i(cfg_w), .cfg_acount_i(cfg_a),
    .busy_o(busy3), .done_o(dn3), .cfg_err_o(ce3), .burst_err_o(be3),
    .w_valid_i(w_valid), .w_ready_o(wr3), .a_valid_i(a_valid), .a_ready_o(ar3),
    .load_row_o(row3), .pe_loadw_o(lw3), .pe_loada_o(la3), .pe_start_o(st3), .pe_sums_o(su3),
    .pe_wcount_o(wc3), .pe_acount_o(ac3), .pe_done_i(pe_done3), .top_sum_done_i(top_done));

  pe_column_ctrl #(.NUM_ROWS(1), .SPAD_DEPTH(SPAD), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .cfg_wcount_i(cfg_w), .cfg_acount_i(cfg_a),
    .busy_o(busy1), .done_o(dn1), .cfg_err_o(ce1), .burst_err_o(be1),
    .w_valid_i(w_valid), .w_ready_o(wr1), .a_valid_i(a_valid), .a_ready_o(ar1),
    .load_row_o(row1), .pe_loadw_o(lw1), .pe_loada_o(la1), .pe_start_o(st1), .pe_sums_o(su1),
    .pe_wcount_o(wc1), .pe_acount_o(ac1), .pe_done_i(pe_done1), .top_sum_done_i(top_done));

  // Observed groups: ld = {loadw[2:0], loada[2:0], w_ready, a_ready, load_row[1:0]},
  // ctl = {busy, start, sums, done, burst_err, cfg_err}, cfg = {wcount, acount}.
  logic       sel1;
  logic [9:0] obs_ld;
  logic [5:0] obs_ctl;
  logic [15:0] obs_cfg;
  always_comb begin
    if (sel1) begin
      obs_ld  = {2'b00, lw1, 2'b00, la1, wr1, ar1, 1'b0, row1};
      obs_ctl = {busy1, st1, su1, dn1, be1, ce1};
      obs_cfg = {wc1, ac1};
    end else begin
      obs_ld  = {lw3, la3, wr3, ar3, row3};
      obs_ctl = {busy3, st3, su3, dn3, be3, ce3};
      obs_cfg = {wc3, ac3};
    end
  end

  int checks = 0;
  int failures = 0;
  logic [7:0] last_w [2];
  logic [7:0] last_a [2];

  logic [9:0]  e_ld  [MAXT];
  logic [5:0]  e_ctl [MAXT];
  logic [15:0] e_cfg [MAXT];
  bit          s_wv [MAXT];
  bit          s_av [MAXT];
  bit          s_st [MAXT];
  bit          s_top[MAXT];
  bit          s_rst[MAXT];
  logic [2:0]  s_pd [MAXT];
  int          plen;

  function automatic bit legal_ref(input int w, input int a);
    return (w >= 1) && (w <= a) && (a <= SPAD) && (a - w + 2 <= SPAD);
  endfunction

  task automatic quiet_inputs();
    start3 = 0; start1 = 0; w_valid = 0; a_valid = 0; top_done = 0;
    pe_done3 = '0; pe_done1 = 0; rst = 0;
  endtask

  // Builds the expected per-cycle timeline of a pass, then drives it and compares every cycle.
  task automatic do_pass(input string tag, input bit use1, input int wc, input int ac,
                         input int lowpct, input bit directed, input int d0, input int d1,
                         input int d2, input bit early_top, input bit hold_start, input int rst_cyc);
    int nr, li, t, k, len, drops, stall, nps, cs, maxd, f, td, rs;
    int doff[3];
    bit v, dropped;
    logic [2:0] rb;
    logic [1:0] r2;
    nr = use1 ? 1 : 3;
    li = use1 ? 1 : 0;
    doff[0] = d0; doff[1] = d1; doff[2] = d2;
    for (int i = 0; i < MAXT; i++) begin
      e_ld[i] = '0; e_ctl[i] = '0; e_cfg[i] = {wc[7:0], ac[7:0]};
      s_wv[i] = 0; s_av[i] = 0; s_st[i] = 0; s_top[i] = 0; s_rst[i] = 0; s_pd[i] = '0;
    end
    e_cfg[0] = {last_w[li], last_a[li]};
    s_st[0] = 1;
    nps = ac - wc + 2;
    t = 1;
    for (int ph = 0; ph < 2; ph++) begin
      len = (ph == 0) ? wc : ac;
      for (int r = 0; r < nr; r++) begin
        k = 0; drops = 0; dropped = 0;
        stall = (directed && ph == 0 && r == 1) ? 2 : 0;
        r2 = r[1:0];
        while (k < len) begin
          if (stall > 0) begin v = 0; stall--; end
          else if (directed && ph == 0 && r == 1 && k == 2 && !dropped) begin v = 0; dropped = 1; end
          else if (drops < 2 && t < MAXT - 120 && int'($urandom_range(99)) < lowpct) v = 0;
          else v = 1;
          rb = v ? (3'b001 << r) : 3'b000;
          if (ph == 0) begin
            s_wv[t] = v; s_av[t] = 1'($urandom_range(1));
            e_ld[t] = {rb, 3'b000, v, 1'b0, r2};
          end else begin
            s_av[t] = v; s_wv[t] = 1'($urandom_range(1));
            e_ld[t] = {3'b000, rb, 1'b0, v, r2};
          end
          if ($urandom_range(3) == 0) s_pd[t] = 3'($urandom_range(7));
          e_ctl[t][5] = 1'b1;
          if (v) k++;
          else if (k > 0) begin k = 0; drops++; e_ctl[t+1][1] = 1'b1; end
          t++;
        end
      end
    end
    e_ctl[t][5] = 1'b1; e_ctl[t][4] = 1'b1;
    t++;
    cs = t; maxd = 0;
    for (int r = 0; r < nr; r++) begin
      s_pd[cs + doff[r]][r] = 1'b1;
      if (doff[r] > maxd) maxd = doff[r];
    end
    for (int i = cs; i <= cs + maxd; i++) e_ctl[i][5] = 1'b1;
    f = cs + maxd + 1;
    for (int i = f; i < f + nps; i++) begin e_ctl[i][5] = 1'b1; e_ctl[i][3] = 1'b1; end
    td = early_top ? f + nps - 1 : f + nps + nr - 1;
    for (int i = f + nps; i <= td; i++) e_ctl[i][5] = 1'b1;
    s_top[td] = 1;
    e_ctl[td+1][2] = 1'b1;
    plen = td + 3;
    if (hold_start) for (int i = 0; i <= td; i++) s_st[i] = 1;
    if (rst_cyc > 0) begin
      rs = f + rst_cyc - 1;
      for (int i = rs + 1; i < MAXT; i++) begin
        e_ld[i] = '0; e_ctl[i] = '0; e_cfg[i] = '0;
        s_top[i] = 0; s_pd[i] = '0; s_st[i] = 0;
      end
      s_rst[rs] = 1;
      plen = rs + 3;
    end

    sel1 = use1;
    for (int s = 0; s < plen; s++) begin
      @(posedge clk); #1;
      rst = s_rst[s];
      start3 = use1 ? 1'b0 : s_st[s];
      start1 = use1 ? s_st[s] : 1'b0;
      w_valid = s_wv[s]; a_valid = s_av[s]; top_done = s_top[s];
      pe_done3 = s_pd[s]; pe_done1 = s_pd[s][0];
      cfg_w = wc[7:0]; cfg_a = ac[7:0];
      @(negedge clk);
      checks++;
      if (obs_ld !== e_ld[s]) begin
        failures++;
        $display("FAIL %s load_strobes cycle %0d: got %b expected %b", tag, s, obs_ld, e_ld[s]);
      end
      checks++;
      if (obs_ctl !== e_ctl[s]) begin
        failures++;
        $display("FAIL %s ctrl{busy,start,sums,done,berr,cerr} cycle %0d: got %b expected %b", tag, s, obs_ctl, e_ctl[s]);
      end
      checks++;
      if (obs_cfg !== e_cfg[s]) begin
        failures++;
        $display("FAIL %s counts cycle %0d: got %h expected %h", tag, s, obs_cfg, e_cfg[s]);
      end
    end
    quiet_inputs();
    if (rst_cyc > 0) begin
      last_w[0] = '0; last_a[0] = '0; last_w[1] = '0; last_a[1] = '0;
    end else begin
      last_w[li] = wc[7:0]; last_a[li] = ac[7:0];
    end
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst = 1; start3 = 1; start1 = 1; w_valid = 1; a_valid = 1; cfg_w = 8'd3; cfg_a = 8'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel1 = d[0];
      #0;
      checks++;
      if (obs_ld !== '0) begin failures++; $display("FAIL reset_strobes dut%0d: got %b expected 0", d, obs_ld); end
      checks++;
      if (obs_ctl !== '0) begin failures++; $display("FAIL reset_ctrl dut%0d: got %b expected 0", d, obs_ctl); end
      checks++;
      if (obs_cfg !== '0) begin failures++; $display("FAIL reset_counts dut%0d: got %h expected 0", d, obs_cfg); end
    end
    quiet_inputs();
    last_w[0] = '0; last_a[0] = '0; last_w[1] = '0; last_a[1] = '0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    do_pass("nominal", 1'b0, 3, 5, 0, 1'b0, int'($urandom_range(4)), int'($urandom_range(4)),
            int'($urandom_range(4)), 1'b0, 1'b0, 0);
  endtask

  task automatic test_stall_break();
    do_pass("stall_break", 1'b0, 3, 5, 0, 1'b1, 2, 1, 3, 1'b0, 1'b0, 0);
  endtask

  task automatic test_cfg_errors();
    int tw[4] = '{0, 6, 3, 1};
    int ta[4] = '{5, 5, 17, 16};
    int w, a, tries;
    sel1 = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin w = tw[i]; a = ta[i]; end
      else begin
        tries = 0;
        do begin w = int'($urandom_range(20)); a = int'($urandom_range(20)); tries++; end
        while (legal_ref(w, a) && tries < 100);
        if (legal_ref(w, a)) begin w = 0; a = 4; end
      end
      @(posedge clk); #1;
      start3 = 1; cfg_w = w[7:0]; cfg_a = a[7:0]; w_valid = 1; a_valid = 1;
      @(posedge clk); #1;
      start3 = 0;
      @(negedge clk);
      checks++;
      if (obs_ctl !== 6'b000001) begin failures++; $display("FAIL cfg_err w=%0d a=%0d: ctrl got %b expected 000001", w, a, obs_ctl); end
      checks++;
      if (obs_ld !== '0) begin failures++; $display("FAIL cfg_err_strobes w=%0d a=%0d: got %b expected 0", w, a, obs_ld); end
      checks++;
      if (obs_cfg !== {last_w[0], last_a[0]}) begin
        failures++; $display("FAIL cfg_err_counts w=%0d a=%0d: got %h expected %h", w, a, obs_cfg, {last_w[0], last_a[0]});
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (obs_ctl !== '0) begin failures++; $display("FAIL cfg_err_oneshot w=%0d a=%0d: ctrl got %b expected 0", w, a, obs_ctl); end
      quiet_inputs();
    end
    do_pass("legal_after_err", 1'b0, 2, 7, 10, 1'b0, 1, 0, 2, 1'b0, 1'b0, 0);
  endtask

  task automatic test_staggered_done();
    do_pass("staggered", 1'b0, 3, 5, 0, 1'b0, 10, 12, 15, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_sums();
    do_pass("rst_mid_sums", 1'b0, 3, 5, 0, 1'b0, 0, 2, 1, 1'b0, 1'b0, 2);
    do_pass("after_rst", 1'b0, 3, 5, 0, 1'b0, 3, 0, 1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_edge_config();
    do_pass("edge_16_16", 1'b1, 16, 16, 0, 1'b0, int'($urandom_range(5)), 0, 0, 1'b1, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    int w, a;
    for (int i = 0; i < 6; i++) begin
      w = int'($urandom_range(1, 16));
      a = w + int'($urandom_range(0, 14));
      if (a > SPAD) a = SPAD;
      do_pass("random", (i >= 4), w, a, 15, 1'b0, int'($urandom_range(6)),
              int'($urandom_range(6)), int'($urandom_range(6)), 1'b0, 1'b0, 0);
    end
  endtask

  initial begin
    sel1 = 0; cfg_w = '0; cfg_a = '0;
    quiet_inputs();
    test_reset();
    test_nominal();
    test_stall_break();
    test_cfg_errors();
    test_staggered_done();
    test_reset_mid_sums();
    test_edge_config();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
